// File: rtl/wifi_rx_sym2bit_serializer_pkg.sv
// Shared definitions for the WiFi RX symbol-to-bit path: modulation codes,
// bits-per-symbol lookup and the serializer state encoding.
package wifi_rx_pkg;

    localparam int MAX_BPS_DEFAULT = 6;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

    function automatic logic [2:0] bps_of(input logic [1:0] mode);
        case (mod_t'(mode))
            MOD_BPSK:  return 3'd1;
            MOD_QPSK:  return 3'd2;
            MOD_16QAM: return 3'd4;
            default:   return 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/wifi_rx_sym2bit_serializer_if.sv
// Handshake bundle between the demapper, the serializer and the deinterleaver.
interface wifi_rx_sym2bit_serializer_if #(
    parameter int MAX_BPS = 6,
    parameter int LVL_W   = 3
);
    logic [1:0]         mode;
    logic               flush;
    logic               sym_valid;
    logic               sym_ready;
    logic [MAX_BPS-1:0] sym_data;
    logic               sym_last;
    logic               bit_valid;
    logic               bit_ready;
    logic               bit_data;
    logic               bit_last;
    logic [LVL_W-1:0]   fifo_level;

    modport master (
        output mode, flush, sym_valid, sym_data, sym_last, bit_ready,
        input  sym_ready, bit_valid, bit_data, bit_last, fifo_level
    );

    modport slave (
        input  mode, flush, sym_valid, sym_data, sym_last, bit_ready,
        output sym_ready, bit_valid, bit_data, bit_last, fifo_level
    );
endinterface

// File: rtl/wifi_rx_sym2bit_serializer_fifo.sv
// Small symbol FIFO with combinational head read so a freshly loaded symbol
// can start shifting on the next edge; flush wins over push and pop.
module wifi_rx_sym_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == LVL_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + LVL_W'(1);
                2'b01:   count_reg <= count_reg - LVL_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wifi_rx_sym2bit_serializer.sv
// Symbol-to-bit serializer: queues demapped symbols with their captured
// modulation and shifts them out MSB-first, one bit per accepted cycle.
module wifi_rx_sym2bit_serializer
    import wifi_rx_pkg::*;
#(
    parameter int MAX_BPS    = MAX_BPS_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    wifi_rx_sym2bit_serializer_if.slave bus
);
    localparam int ENTRY_W = MAX_BPS + 3;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    logic [MAX_BPS-1:0] head_data;
    logic [1:0]         head_mode;
    logic               head_last;
    logic [2:0]         head_bps;
    logic [MAX_BPS-1:0] head_aligned;

    shift_state_t       state_reg, state_next;
    logic [MAX_BPS-1:0] shift_reg, shift_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [2:0]         bps_reg, bps_next;
    logic               last_reg, last_next;

    logic               consume;
    logic               sym_done;
    logic               out_valid;
    logic               out_data;
    logic               out_last;

    assign wr_entry = {bus.sym_last, bus.mode, bus.sym_data};

    wifi_rx_sym_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.flush),
        .push    (bus.sym_valid),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head_entry),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_data = head_entry[MAX_BPS-1:0];
    assign head_mode = head_entry[MAX_BPS+1:MAX_BPS];
    assign head_last = head_entry[MAX_BPS+2];
    assign head_bps  = bps_of(head_mode);

    // Left-align the used bits so the MSB always leaves from the top of the
    // shifter; unused upper sym_data bits fall off here.
    assign head_aligned = head_data << (MAX_BPS - int'(head_bps));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            bps_reg   <= 3'd1;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            bps_reg   <= bps_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        consume    = (state_reg == ST_SHIFT) && bus.bit_ready;
        sym_done   = consume && (cnt_reg == bps_reg - 3'd1);
        fifo_pop   = !bus.flush && !fifo_empty && ((state_reg == ST_IDLE) || sym_done);
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        bps_next   = bps_reg;
        last_next  = last_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
            shift_next = '0;
            cnt_next   = '0;
            bps_next   = 3'd1;
            last_next  = 1'b0;
        end else if (fifo_pop) begin
            // Loading on the final-bit handshake keeps symbols back-to-back.
            state_next = ST_SHIFT;
            shift_next = head_aligned;
            cnt_next   = '0;
            bps_next   = head_bps;
            last_next  = head_last;
        end else if (sym_done) begin
            state_next = ST_IDLE;
            shift_next = '0;
            cnt_next   = '0;
        end else if (consume) begin
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg + 3'd1;
        end
    end

    always_comb begin
        out_valid = (state_reg == ST_SHIFT);
        out_data  = out_valid && shift_reg[MAX_BPS-1];
        out_last  = out_valid && last_reg && (cnt_reg == bps_reg - 3'd1);
    end

    assign bus.bit_valid  = out_valid;
    assign bus.bit_data   = out_data;
    assign bus.bit_last   = out_last;
    assign bus.sym_ready  = !fifo_full;
    assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_wifi_rx_sym2bit_serializer.sv
// Bench for the symbol-to-bit serializer: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference.
module tb_wifi_rx_sym2bit_serializer;
    import wifi_rx_pkg::*;

    localparam int MAX_BPS    = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wifi_rx_sym2bit_serializer_if #(.MAX_BPS(MAX_BPS), .LVL_W(LVL_W)) bus_if ();

    wifi_rx_sym2bit_serializer #(
        .MAX_BPS    (MAX_BPS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sv;
        logic [1:0] md;
        logic [5:0] sd;
        logic       sl;
        logic       br;
        logic       ev;
        logic       ed;
        logic       el;
        logic [2:0] elvl;
    } vec_t;

    typedef struct {
        logic [5:0] d;
        logic [1:0] m;
        logic       l;
    } msym_t;

    typedef struct {
        logic b;
        logic l;
    } mbit_t;

    vec_t  tbl [25];
    msym_t mfifo [$];
    mbit_t mcur [$];
    logic  eb [$];
    logic  el [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bps_ref(input logic [1:0] m);
        int tab [4] = '{1, 2, 4, 6};
        return tab[m];
    endfunction

    function automatic vec_t mk(input logic sv, input logic [1:0] md, input logic [5:0] sd,
                                input logic sl, input logic br, input logic ev,
                                input logic ed, input logic e_l, input logic [2:0] elvl);
        vec_t v;
        v.sv = sv; v.md = md; v.sd = sd; v.sl = sl; v.br = br;
        v.ev = ev; v.ed = ed; v.el = e_l; v.elvl = elvl;
        return v;
    endfunction

    task automatic drive(input logic sv, input logic [1:0] md, input logic [5:0] sd,
                         input logic sl, input logic br, input logic fl);
        bus_if.sym_valid = sv;
        bus_if.mode      = md;
        bus_if.sym_data  = sd;
        bus_if.sym_last  = sl;
        bus_if.bit_ready = br;
        bus_if.flush     = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int outs();
        return int'({bus_if.bit_valid, bus_if.bit_data, bus_if.bit_last,
                     bus_if.fifo_level, bus_if.sym_ready});
    endfunction

    function automatic int pack_exp(input logic v, input logic d, input logic l,
                                    input logic [2:0] lvl);
        logic r;
        r = (int'(lvl) < FIFO_DEPTH);
        return int'({v, v & d, v & l, lvl, r});
    endfunction

    function automatic int model_outs();
        logic v;
        v = (mcur.size() > 0);
        return pack_exp(v, v ? mcur[0].b : 1'b0, v ? mcur[0].l : 1'b0, 3'(mfifo.size()));
    endfunction

    // Reference behaviour at one clock edge, using the inputs present at it.
    task automatic model_step();
        bit    full_pre;
        bit    has_head;
        msym_t s;
        int    n;
        if (bus_if.flush) begin
            mfifo.delete();
            mcur.delete();
            return;
        end
        full_pre = (mfifo.size() == FIFO_DEPTH);
        has_head = (mfifo.size() > 0);
        if (mcur.size() > 0 && bus_if.bit_ready) void'(mcur.pop_front());
        if (mcur.size() == 0 && has_head) begin
            s = mfifo.pop_front();
            n = bps_ref(s.m);
            for (int i = n - 1; i >= 0; i--) mcur.push_back('{b: s.d[i], l: (s.l && i == 0)});
        end
        if (bus_if.sym_valid && !full_pre)
            mfifo.push_back('{d: bus_if.sym_data, m: bus_if.mode, l: bus_if.sym_last});
    endtask

    task automatic drain(input string name);
        int k = 0;
        for (int t = 0; t < 40; t++) begin
            if (!bus_if.bit_valid) break;
            if (k < eb.size()) begin
                check({name, "_bit"}, int'(bus_if.bit_data), int'(eb[k]));
                check({name, "_last"}, int'(bus_if.bit_last), int'(el[k]));
            end
            k++;
            cyc();
        end
        check({name, "_count"}, k, eb.size());
    endtask

    task automatic expect_sym(input logic [5:0] d, input logic [1:0] m, input logic l);
        int n = bps_ref(m);
        for (int i = n - 1; i >= 0; i--) begin
            eb.push_back(d[i]);
            el.push_back(l && i == 0);
        end
    endtask

    initial begin
        // QPSK pair, 64-QAM plus BPSK with ignored upper bits, mixed-mode queue.
        tbl[0]  = mk(1, 2'd1, 6'b000010, 0, 1, 0, 0, 0, 3'd1);
        tbl[1]  = mk(1, 2'd1, 6'b000001, 1, 1, 1, 1, 0, 3'd1);
        tbl[2]  = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[3]  = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd0);
        tbl[4]  = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 1, 3'd0);
        tbl[5]  = mk(0, 2'd0, 6'b000000, 0, 1, 0, 0, 0, 3'd0);
        tbl[6]  = mk(1, 2'd3, 6'b101100, 0, 1, 0, 0, 0, 3'd1);
        tbl[7]  = mk(1, 2'd0, 6'b111110, 1, 1, 1, 1, 0, 3'd1);
        tbl[8]  = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[9]  = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 0, 3'd1);
        tbl[10] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 0, 3'd1);
        tbl[11] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[12] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[13] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 1, 3'd0);
        tbl[14] = mk(0, 2'd0, 6'b000000, 0, 1, 0, 0, 0, 3'd0);
        tbl[15] = mk(1, 2'd0, 6'b000001, 0, 1, 0, 0, 0, 3'd1);
        tbl[16] = mk(1, 2'd2, 6'b000110, 0, 0, 1, 1, 0, 3'd1);
        tbl[17] = mk(1, 2'd1, 6'b000011, 1, 0, 1, 1, 0, 3'd2);
        tbl[18] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[19] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 0, 3'd1);
        tbl[20] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 0, 3'd1);
        tbl[21] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 0, 0, 3'd1);
        tbl[22] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 0, 3'd0);
        tbl[23] = mk(0, 2'd0, 6'b000000, 0, 1, 1, 1, 1, 3'd0);
        tbl[24] = mk(0, 2'd0, 6'b000000, 0, 1, 0, 0, 0, 3'd0);

        drive(0, 2'd0, 6'd0, 0, 1, 0);
        repeat (2) @(negedge clk);
        check("reset_state", outs(), pack_exp(0, 0, 0, 3'd0));
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].sv, tbl[i].md, tbl[i].sd, tbl[i].sl, tbl[i].br, 0);
            cyc();
            $display("vec %0d: sv=%0b mode=%0d data=%b -> valid=%0b bit=%0b last=%0b level=%0d",
                     i, tbl[i].sv, tbl[i].md, tbl[i].sd, bus_if.bit_valid, bus_if.bit_data,
                     bus_if.bit_last, bus_if.fifo_level);
            check($sformatf("vec%0d", i), outs(),
                  pack_exp(tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].elvl));
        end

        // Backpressure: downstream stalled while upstream keeps offering QPSK.
        eb.delete(); el.delete();
        for (int c = 0; c < 10; c++) begin
            logic [5:0] v = 6'((c * 3 + 2) & 3);
            drive(1, 2'd1, v, 0, 0, 0);
            if (c < 5) expect_sym(v, 2'd1, 0);
            cyc();
            if (c >= 1) begin
                check("stall_valid", int'(bus_if.bit_valid), 1);
                check("stall_hold", int'(bus_if.bit_data), int'(eb[0]));
            end
        end
        check("stall_level", int'(bus_if.fifo_level), FIFO_DEPTH);
        check("stall_ready", int'(bus_if.sym_ready), 0);
        $display("backpressure: level=%0d ready=%0b", bus_if.fifo_level, bus_if.sym_ready);
        drive(0, 2'd0, 6'd0, 0, 1, 0);
        drain("stall_drain");

        // Flush mid-16QAM with two entries queued, with a push in the same cycle.
        drive(1, 2'd2, 6'b000101, 0, 0, 0); cyc();
        drive(1, 2'd2, 6'b001010, 0, 0, 0); cyc();
        drive(1, 2'd2, 6'b001100, 0, 0, 0); cyc();
        drive(0, 2'd0, 6'd0, 0, 1, 0); cyc();
        check("preflush", outs(), pack_exp(1, 1, 0, 3'd2));
        drive(1, 2'd2, 6'b001111, 0, 1, 1); cyc();
        check("flush", outs(), pack_exp(0, 0, 0, 3'd0));
        $display("flush: valid=%0b level=%0d ready=%0b", bus_if.bit_valid, bus_if.fifo_level,
                 bus_if.sym_ready);
        drive(1, 2'd2, 6'b001001, 1, 1, 0); cyc();
        check("postflush_push", outs(), pack_exp(0, 0, 0, 3'd1));
        drive(0, 2'd0, 6'd0, 0, 1, 0); cyc();
        eb.delete(); el.delete();
        expect_sym(6'b001001, 2'd2, 1);
        drain("postflush");

        // Asynchronous reset in the middle of a 64-QAM symbol.
        drive(1, 2'd3, 6'b101101, 0, 1, 0); cyc();
        drive(1, 2'd3, 6'b010011, 0, 1, 0); cyc();
        drive(0, 2'd0, 6'd0, 0, 1, 0); cyc();
        check("prereset", outs(), pack_exp(1, 0, 0, 3'd1));
        #2 reset = 1'b0;
        #1 check("async_reset", outs(), pack_exp(0, 0, 0, 3'd0));
        $display("async reset: valid=%0b level=%0d", bus_if.bit_valid, bus_if.fifo_level);
        cyc();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            check("after_reset", outs(), pack_exp(0, 0, 0, 3'd0));
        end
        drive(1, 2'd0, 6'b000001, 1, 1, 0); cyc();
        drive(0, 2'd0, 6'd0, 0, 1, 0); cyc();
        eb.delete(); el.delete();
        expect_sym(6'b000001, 2'd0, 1);
        drain("post_reset");

        // Randomized traffic against the queue model.
        drive(0, 2'd0, 6'd0, 0, 1, 1);
        @(posedge clk); model_step(); @(negedge clk);
        check("rand_start", outs(), model_outs());
        for (int c = 0; c < 3000; c++) begin
            if (c < 2950)
                drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 6'($urandom),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 79) == 0);
            else
                drive(0, 2'd0, 6'd0, 0, 1, 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check($sformatf("rand%0d", c), outs(), model_outs());
        end
        $display("random phase: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
